// File: rtl/ntt_bf_sequencer_if.sv
// Purpose : bundle of the start/status, read-issue and write-back signals of
//           ntt_bf_sequencer. master = sequencer side, slave = datapath/host side.
// Ports   : start/mode (and stall_in when NTT_BF_SEQ_STALL_EN is defined) flow
//           into the sequencer; busy/done/stage/sel, read and write strobes and
//           addresses flow out of it.
interface ntt_bf_sequencer_if #(
  parameter int LOGN = 8
);
  logic            start;
  logic            mode;
  logic            busy;
  logic            done;
  logic [LOGN-1:0] stage;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_u;
  logic [LOGN-1:0] rd_addr_v;
  logic [LOGN-1:0] tw_addr;
  logic            sel;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_u;
  logic [LOGN-1:0] wr_addr_v;
`ifdef NTT_BF_SEQ_STALL_EN
  logic            stall_in;

  modport master (
    input  start, mode, stall_in,
    output busy, done, stage, rd_en, rd_addr_u, rd_addr_v, tw_addr, sel,
           wr_en, wr_addr_u, wr_addr_v
  );
  modport slave (
    output start, mode, stall_in,
    input  busy, done, stage, rd_en, rd_addr_u, rd_addr_v, tw_addr, sel,
           wr_en, wr_addr_u, wr_addr_v
  );
`else
  modport master (
    input  start, mode,
    output busy, done, stage, rd_en, rd_addr_u, rd_addr_v, tw_addr, sel,
           wr_en, wr_addr_u, wr_addr_v
  );
  modport slave (
    output start, mode,
    input  busy, done, stage, rd_en, rd_addr_u, rd_addr_v, tw_addr, sel,
           wr_en, wr_addr_u, wr_addr_v
  );
`endif
endinterface

// File: rtl/ntt_bf_sequencer.sv
// Purpose : address/control sequencer for one full in-place NTT (CT) or INTT (GS)
//           pass over N = 2^LOGN coefficients through a radix-2 butterfly.
// Latency : reads issue the cycle after start; writes trail reads by
//           D = READ_LAT + LAT_CT/LAT_GS; done at LOGN*(N/2+D)+1 (+ stalled cycles).
// Backpr. : optional stall_in (macro NTT_BF_SEQ_STALL_EN) freezes issue in RUN and
//           injects bubbles into the write-back delay line; otherwise none.
// Ports   : clk, rst (async, active low), bus (ntt_bf_sequencer_if.master).
module ntt_bf_sequencer #(
  parameter int LOGN     = 8,
  parameter int READ_LAT = 1,
  parameter int LAT_CT   = 6,
  parameter int LAT_GS   = 6
) (
  input  logic                clk,
  input  logic                rst,
  ntt_bf_sequencer_if.master  bus
);
  localparam int N    = 1 << LOGN;
  localparam int HALF = N / 2;
  localparam int D_CT = READ_LAT + LAT_CT;
  localparam int D_GS = READ_LAT + LAT_GS;
  localparam int DMAX = (D_CT > D_GS) ? D_CT : D_GS;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int TW   = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam logic [LOGN-1:0] ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state, state_n;
  logic [LOGN-1:0] k, k_n, stage, stage_n;
  logic            mode_q, mode_n;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic            issue;
  logic            stall;

`ifdef NTT_BF_SEQ_STALL_EN
  assign stall = bus.stall_in;
`else
  assign stall = 1'b0;
`endif

  // Last DRAIN count and delay-line tap both follow the mode latched at start.
  logic [DW-1:0] dlast;
  logic [TW-1:0] tap;
  assign dlast = mode_q ? DW'(D_GS - 1) : DW'(D_CT - 1);
  assign tap   = mode_q ? TW'(D_GS - 1) : TW'(D_CT - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      k      <= '0;
      stage  <= '0;
      mode_q <= 1'b0;
      dcnt   <= '0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      stage  <= stage_n;
      mode_q <= mode_n;
      dcnt   <= dcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    stage_n = stage;
    mode_n  = mode_q;
    dcnt_n  = dcnt;
    issue   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          mode_n  = bus.mode;
          k_n     = '0;
          stage_n = '0;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall) begin
          issue = 1'b1;
          if (k == LOGN'(HALF - 1)) begin
            dcnt_n  = '0;
            state_n = S_DRAIN;
          end else begin
            k_n = k + ONE;
          end
        end
      end
      S_DRAIN: begin
        if (dcnt == dlast) begin
          dcnt_n = '0;
          if (stage == LOGN'(LOGN - 1)) begin
            state_n = S_DONE;
          end else begin
            stage_n = stage + ONE;
            k_n     = '0;
            state_n = S_RUN;
          end
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      S_DONE: begin
        stage_n = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // len = 2^sh_len, so k/len and k%len reduce to a shift and a mask.
  // CT and GS swap the roles of the span and twiddle-base exponents.
  logic [LOGN-1:0] sh_len, sh_tw, len, grp, off, addr_u, addr_v, tw;
  always_comb begin
    sh_len = mode_q ? stage : (LOGN'(LOGN - 1) - stage);
    sh_tw  = mode_q ? (LOGN'(LOGN - 1) - stage) : stage;
    len    = ONE << sh_len;
    grp    = k >> sh_len;
    off    = k & (len - ONE);
    addr_u = (grp << (sh_len + ONE)) | off;
    addr_v = addr_u + len;
    tw     = (ONE << sh_tw) + grp;
  end

  // Write-back delay line: shifts every cycle so stalls and drains appear as bubbles.
  logic            dl_en [DMAX];
  logic [LOGN-1:0] dl_u  [DMAX];
  logic [LOGN-1:0] dl_v  [DMAX];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMAX; i++) begin
        dl_en[i] <= 1'b0;
        dl_u[i]  <= '0;
        dl_v[i]  <= '0;
      end
    end else begin
      dl_en[0] <= issue;
      dl_u[0]  <= issue ? addr_u : '0;
      dl_v[0]  <= issue ? addr_v : '0;
      for (int i = 1; i < DMAX; i++) begin
        dl_en[i] <= dl_en[i-1];
        dl_u[i]  <= dl_u[i-1];
        dl_v[i]  <= dl_v[i-1];
      end
    end
  end

  logic in_run;
  assign in_run        = (state == S_RUN);
  assign bus.busy      = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done      = (state == S_DONE);
  assign bus.stage     = stage;
  assign bus.sel       = mode_q;
  assign bus.rd_en     = issue;
  assign bus.rd_addr_u = in_run ? addr_u : '0;
  assign bus.rd_addr_v = in_run ? addr_v : '0;
  assign bus.tw_addr   = in_run ? tw : '0;
  assign bus.wr_en     = dl_en[tap];
  assign bus.wr_addr_u = dl_u[tap];
  assign bus.wr_addr_v = dl_v[tap];
endmodule

// File: tb/tb_ntt_bf_sequencer.sv
// Purpose : directed self-checking bench for ntt_bf_sequencer (LOGN=8, D=7).
// Latency : cycle 0 is the cycle start is driven; outputs sampled 1 time unit
//           after each rising edge.
// Backpr. : stall_in exercised only when NTT_BF_SEQ_STALL_EN is defined.
module tb_ntt_bf_sequencer;
  localparam int LOGN = 8;
  localparam int N    = 1 << LOGN;
  localparam int HALF = N / 2;
  localparam int D    = 7;
  localparam int SL   = HALF + D;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ntt_bf_sequencer_if #(.LOGN(LOGN)) bus ();

  ntt_bf_sequencer #(
    .LOGN(LOGN), .READ_LAT(1), .LAT_CT(6), .LAT_GS(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference addressing written with plain divide/modulo.
  function automatic void exp_addr(input int m, input int s, input int k,
                                   output int u, output int v, output int t);
    int len, grp, off;
    len = m ? (1 << s) : (N >> (s + 1));
    grp = k / len;
    off = k % len;
    u   = grp * 2 * len + off;
    v   = u + len;
    t   = m ? ((N >> (s + 1)) + grp) : ((1 << s) + grp);
  endfunction

  task automatic run_xform(input bit m, input bit abuse);
    int total, s, p, eu, ev, et;
    total = LOGN * SL + 1;
    bus.mode  = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= total; c++) begin
      if (c < total) begin
        s = (c - 1) / SL;
        p = (c - 1) % SL;
        chk("busy", 32'(bus.busy), 1);
        chk("done_early", 32'(bus.done), 0);
        chk("stage", 32'(bus.stage), s);
        chk("rd_en", 32'(bus.rd_en), (p < HALF) ? 1 : 0);
        chk("wr_en", 32'(bus.wr_en), (p >= D) ? 1 : 0);
        if (p < HALF) begin
          exp_addr(m, s, p, eu, ev, et);
          chk("rd_addr_u", 32'(bus.rd_addr_u), eu);
          chk("rd_addr_v", 32'(bus.rd_addr_v), ev);
          chk("tw_addr", 32'(bus.tw_addr), et);
        end
        if (p >= D) begin
          exp_addr(m, s, p - D, eu, ev, et);
          chk("wr_addr_u", 32'(bus.wr_addr_u), eu);
          chk("wr_addr_v", 32'(bus.wr_addr_v), ev);
        end
      end else begin
        chk("done_pulse", 32'(bus.done), 1);
        chk("busy_at_done", 32'(bus.busy), 0);
        chk("rd_en_at_done", 32'(bus.rd_en), 0);
        chk("wr_en_at_done", 32'(bus.wr_en), 0);
      end
      chk("sel", 32'(bus.sel), 32'(m));
      // Hand-computed spot values.
      if (!m && c == 1) begin
        chk("ct_s0k0_u", 32'(bus.rd_addr_u), 0);
        chk("ct_s0k0_v", 32'(bus.rd_addr_v), 128);
        chk("ct_s0k0_tw", 32'(bus.tw_addr), 1);
      end
      if (!m && c == 7 * SL + 128) begin
        chk("ct_s7k127_u", 32'(bus.rd_addr_u), 254);
        chk("ct_s7k127_v", 32'(bus.rd_addr_v), 255);
        chk("ct_s7k127_tw", 32'(bus.tw_addr), 255);
      end
      if (m && c == 6) begin
        chk("gs_s0k5_u", 32'(bus.rd_addr_u), 10);
        chk("gs_s0k5_v", 32'(bus.rd_addr_v), 11);
        chk("gs_s0k5_tw", 32'(bus.tw_addr), 133);
      end
      if (m && c == 7 * SL + 1) begin
        chk("gs_s7k0_u", 32'(bus.rd_addr_u), 0);
        chk("gs_s7k0_v", 32'(bus.rd_addr_v), 128);
        chk("gs_s7k0_tw", 32'(bus.tw_addr), 1);
      end
      if (c == SL) chk("barrier_last_wr", 32'(bus.wr_en), 1);
      if (c == SL + 1) chk("barrier_next_rd", 32'(bus.rd_en), 1);
      if (c == 1081) chk("done_cycle_1081", 32'(bus.done), 1);
      if (abuse) begin
        if (c == 40)  begin bus.start = 1'b1; bus.mode = ~m; end
        if (c == 41)  bus.start = 1'b0;
        if (c == 600) bus.start = 1'b1;
        if (c == 603) begin bus.start = 1'b0; bus.mode = m; end
        if (c == 900) bus.mode = ~m;
        if (c == total) bus.start = 1'b1;
      end
      if (c < total) tick();
    end
    tick();
    bus.start = 1'b0;
    bus.mode  = m;
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_done", 32'(bus.done), 0);
    tick();
    chk("no_restart_busy", 32'(bus.busy), 0);
    chk("no_second_done", 32'(bus.done), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
`ifdef NTT_BF_SEQ_STALL_EN
    bus.stall_in = 1'b0;
`endif
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rd_en", 32'(bus.rd_en), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_sel", 32'(bus.sel), 0);
    chk("rst_stage", 32'(bus.stage), 0);
    chk("rst_rd_u", 32'(bus.rd_addr_u), 0);
    chk("rst_rd_v", 32'(bus.rd_addr_v), 0);
    chk("rst_tw", 32'(bus.tw_addr), 0);
    chk("rst_wr_u", 32'(bus.wr_addr_u), 0);
    tick();
    rst = 1'b1;
    tick();
    tick();

    run_xform(1'b0, 1'b0);
    run_xform(1'b1, 1'b0);

    // Abort in the middle of stage 3.
    bus.mode  = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3 * SL + 19) tick();
    chk("pre_abort_stage", 32'(bus.stage), 3);
    chk("pre_abort_wr_en", 32'(bus.wr_en), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_rd_en", 32'(bus.rd_en), 0);
    chk("abort_wr_en", 32'(bus.wr_en), 0);
    chk("abort_stage", 32'(bus.stage), 0);
    chk("abort_rd_u", 32'(bus.rd_addr_u), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_no_wr", 32'(bus.wr_en), 0);
    end
    rst = 1'b1;
    tick();
    tick();
    run_xform(1'b1, 1'b0);

    // start and mode wiggled while busy and during DONE.
    run_xform(1'b0, 1'b1);

`ifdef NTT_BF_SEQ_STALL_EN
    begin
      int done_at;
      done_at = -1;
      bus.mode  = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 1100; c++) begin
        if (c == 11) bus.stall_in = 1'b1;
        if (c == 14) bus.stall_in = 1'b0;
        #0;
        if (c == 10) chk("stall_pre_u", 32'(bus.rd_addr_u), 9);
        if (c >= 11 && c <= 13) begin
          chk("stall_rd_en", 32'(bus.rd_en), 0);
          chk("stall_hold_u", 32'(bus.rd_addr_u), 10);
        end
        if (c == 14) begin
          chk("stall_resume_en", 32'(bus.rd_en), 1);
          chk("stall_resume_u", 32'(bus.rd_addr_u), 10);
        end
        if (c == 17) chk("stall_wr_k9", 32'(bus.wr_addr_u), 9);
        if (c >= 18 && c <= 20) chk("stall_wr_gap", 32'(bus.wr_en), 0);
        if (c == 21) begin
          chk("stall_wr_resume", 32'(bus.wr_en), 1);
          chk("stall_wr_k10", 32'(bus.wr_addr_u), 10);
        end
        if (bus.done && done_at < 0) done_at = c;
        tick();
      end
      chk("stall_done_cycle", done_at, 1084);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
